// File: rtl/mmap_tx_logic.sv
// rtl/mmap_tx_logic.sv - BRAM-to-stream transmit engine with completion interrupt
module mmap_tx_logic #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [12:0] length,
  output logic        busy,
  output logic        tx_tvalid,
  output logic [63:0] tx_tdata,
  output logic        tx_tlast,
  input  logic        tx_tready,
  output logic        usr_irq_req,
  input  logic        usr_irq_ack,
  input  logic        msi_enable,
  input  logic [2:0]  msi_vector_width,
  output logic        clkb,
  output logic        enb,
  output logic [7:0]  web,
  output logic [31:0] addrb,
  output logic [63:0] dinb,
  input  logic [63:0] doutb
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, IRQ} state_t;

  state_t      state;
  logic [12:0] len_q;
  logic [12:0] issued;
  logic [12:0] popped;
  logic        inflight;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [63:0] mem [FIFO_DEPTH];
  logic        busy_q;
  logic        irq_q;

  logic        start_ok;
  logic        pop;
  logic        push;
  logic [5:0]  occupancy;
  logic        unused_vec;

  // The MSI width only matters to the interrupt controller upstream.
  assign unused_vec = ^msi_vector_width;

  assign start_ok  = (state == IDLE) && start && (length != 13'd0);
  assign tx_tvalid = (fifo_count != '0);
  assign pop       = tx_tvalid && tx_tready;
  assign push      = inflight;

  // Slots already claimed after this edge: stored words, the read in flight,
  // and the word about to be requested unless a beat leaves at the same time.
  assign occupancy = 6'(fifo_count) + 6'(inflight) + (pop ? 6'd0 : 6'd1);
  assign enb       = (state == RUN) && (issued < len_q) && (occupancy <= 6'(FIFO_DEPTH));

  assign addrb    = BASE_ADDR + {16'b0, issued, 3'b000};
  assign tx_tdata = tx_tvalid ? mem[rd_ptr] : 64'd0;
  assign tx_tlast = tx_tvalid && (popped == len_q - 13'd1);

  assign clkb        = clk;
  assign web         = 8'd0;
  assign dinb        = 64'd0;
  assign busy        = busy_q;
  assign usr_irq_req = irq_q;

  // Read issue, in-flight tracking and FIFO pointer/count bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issued     <= '0;
      popped     <= '0;
      inflight   <= 1'b0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      inflight <= enb;
      if (start_ok) begin
        issued <= '0;
        popped <= '0;
      end else begin
        if (enb) issued <= issued + 13'd1;
        if (pop) popped <= popped + 13'd1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage captures BRAM data one cycle after each read request.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= doutb;
  end

  // Transfer sequencing with registered busy and interrupt request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      len_q  <= '0;
      busy_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            len_q  <= length;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (issued == len_q) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && tx_tlast) begin
            if (msi_enable) begin
              irq_q <= 1'b1;
              state <= IRQ;
            end else begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        IRQ: begin
          if (usr_irq_ack) begin
            irq_q  <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmap_tx_logic.sv
// tb/tb_mmap_tx_logic.sv - self-checking bench for mmap_tx_logic
module tb_mmap_tx_logic;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic [12:0] length;
  logic        busy;
  logic        tx_tvalid;
  logic [63:0] tx_tdata;
  logic        tx_tlast;
  logic        tx_tready;
  logic        usr_irq_req;
  logic        usr_irq_ack;
  logic        msi_enable;
  logic [2:0]  msi_vector_width;
  logic        clkb;
  logic        enb;
  logic [7:0]  web;
  logic [31:0] addrb;
  logic [63:0] dinb;
  logic [63:0] doutb;

  mmap_tx_logic #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .length(length), .busy(busy),
    .tx_tvalid(tx_tvalid), .tx_tdata(tx_tdata), .tx_tlast(tx_tlast), .tx_tready(tx_tready),
    .usr_irq_req(usr_irq_req), .usr_irq_ack(usr_irq_ack), .msi_enable(msi_enable),
    .msi_vector_width(msi_vector_width), .clkb(clkb), .enb(enb), .web(web),
    .addrb(addrb), .dinb(dinb), .doutb(doutb)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Model state: what the transfer in progress must produce.
  bit          active = 0;
  bit          tput_mode = 0;
  int          cur_len = 0;
  int          beat_k = 0;
  int          reads_k = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          first_valid_cyc = -1;
  int          tlast_cyc = 0;
  int          last_acc_cyc = 0;
  int          irq_cycles = 0;
  int          tlast_count = 0;
  int          ready_mode = 0;
  logic [31:0] last_addr = 32'd0;
  logic [63:0] got [16];
  bit          prev_stall = 0;
  logic [63:0] prev_data = 64'd0;
  logic [31:0] pat = 32'b1011_0010_0111_0001_1100_1010_0110_1001;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // BRAM: word n holds n+1, one-cycle read latency.
  always @(posedge clk) begin
    if (enb) doutb <= 64'((addrb - BASE) >> 3) + 64'd1;
  end

  // Sink ready pattern.
  initial begin
    tx_tready = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_tready = 1'b1;
        1:       tx_tready = pat[cyc % 32];
        default: tx_tready = 1'b0;
      endcase
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      bit pop;
      pop = tx_tvalid && tx_tready;
      if (!active) chk("idle_tvalid", tx_tvalid, 0);
      if (prev_stall) begin
        chk("stall_valid", tx_tvalid, 1);
        chk("stall_data", tx_tdata, prev_data);
      end
      if (enb) begin
        chk("enb_bound", reads_k < cur_len, 1);
        chk("addrb", addrb, BASE + 32'(8 * reads_k));
        last_addr = addrb;
      end
      chk("outstanding", (reads_k + int'(enb) - beat_k - int'(pop)) <= DEPTH, 1);
      if (active && tx_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (pop) begin
        chk("beat_data", tx_tdata, 64'(beat_k + 1));
        chk("beat_tlast", tx_tlast, beat_k == cur_len - 1);
        if (beat_k < 16) got[beat_k] = tx_tdata;
        if (tx_tlast) tlast_count++;
        if (tput_mode && beat_k > 0) chk("throughput", cyc - last_acc_cyc, 1);
        last_acc_cyc = cyc;
        beat_k++;
        if (beat_k == cur_len) begin
          active = 0;
          tlast_cyc = cyc;
        end
      end
      if (enb) reads_k++;
      if (usr_irq_req) irq_cycles++;
      prev_stall = tx_tvalid && !tx_tready;
      prev_data = tx_tdata;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic start_xfer(input int len, input bit msi);
    @(posedge clk);
    #1;
    start = 1;
    length = 13'(len);
    msi_enable = msi;
    active = 1;
    cur_len = len;
    beat_k = 0;
    reads_k = 0;
    first_valid_cyc = -1;
    tlast_count = 0;
    irq_cycles = 0;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 0;
    length = 13'd5;
  endtask

  task automatic ignored_start(input int len, input bit exp_busy);
    @(posedge clk);
    #1;
    start = 1;
    length = 13'(len);
    @(negedge clk);
    chk("ignored_start_busy", busy, exp_busy);
    @(posedge clk);
    #1;
    start = 0;
    @(negedge clk);
    chk("ignored_start_busy_after", busy, exp_busy);
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (active && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_timeout", active, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tvalid"}, tx_tvalid, 0);
    chk({tag, "_tlast"}, tx_tlast, 0);
    chk({tag, "_tdata"}, tx_tdata, 0);
    chk({tag, "_irq"}, usr_irq_req, 0);
    chk({tag, "_enb"}, enb, 0);
    chk({tag, "_addrb"}, addrb, BASE);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    start = 0;
    length = 0;
    usr_irq_ack = 0;
    msi_enable = 0;
    msi_vector_width = 3'd2;
    doutb = 64'd0;
    #1;
    reset = 0;
    #1;
    check_reset_outputs("reset0");
    chk("reset0_web", web, 0);
    chk("reset0_dinb", dinb, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1;

    // Four beats at full rate, no interrupt.
    ready_mode = 0;
    tput_mode = 1;
    start_xfer(4, 0);
    wait_done(50);
    @(negedge clk);
    chk("t1_latency", first_valid_cyc - start_cyc, 3);
    chk("t1_d0", got[0], 64'd1);
    chk("t1_d1", got[1], 64'd2);
    chk("t1_d2", got[2], 64'd3);
    chk("t1_d3", got[3], 64'd4);
    chk("t1_tlast_count", tlast_count, 1);
    chk("t1_busy_low", busy, 0);

    // Same transfer with interrupt; an early ack must be ignored.
    start_xfer(4, 1);
    usr_irq_ack = 1;
    @(posedge clk);
    #1;
    usr_irq_ack = 0;
    wait_done(50);
    while (cyc < tlast_cyc + 5) begin
      @(posedge clk);
      #1;
    end
    usr_irq_ack = 1;
    @(negedge clk);
    chk("t2_busy_at_ack", busy, 1);
    chk("t2_req_at_ack", usr_irq_req, 1);
    @(posedge clk);
    #1;
    usr_irq_ack = 0;
    @(negedge clk);
    chk("t2_busy_after_ack", busy, 0);
    chk("t2_req_after_ack", usr_irq_req, 0);
    chk("t2_irq_cycles", irq_cycles, 5);
    chk("t2_d3", got[3], 64'd4);

    // Start during a transfer and zero-length start are ignored.
    start_xfer(4, 0);
    ignored_start(8, 1);
    wait_done(50);
    chk("t3_beats", beat_k, 4);
    @(posedge clk);
    #1;
    ignored_start(0, 0);
    @(negedge clk);
    chk("t3_len0_enb", enb, 0);
    chk("t3_len0_busy", busy, 0);

    // Sixteen beats with a long initial stall then a toggling sink.
    tput_mode = 0;
    ready_mode = 2;
    start_xfer(16, 0);
    while (cyc < start_cyc + 10) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("t4_stall_enb", enb, 0);
    chk("t4_stall_reads", reads_k, DEPTH);
    chk("t4_stall_tvalid", tx_tvalid, 1);
    ready_mode = 1;
    wait_done(500);
    chk("t4_beats", beat_k, 16);
    chk("t4_d15", got[15], 64'd16);
    chk("t4_tlast_count", tlast_count, 1);

    // Maximum length.
    ready_mode = 0;
    tput_mode = 1;
    start_xfer(4096, 0);
    wait_done(5000);
    chk("t5_last_addr", last_addr, BASE + 32'h7FF8);
    chk("t5_beats", beat_k, 4096);
    chk("t5_reads", reads_k, 4096);
    chk("t5_tlast_count", tlast_count, 1);

    // Reset in the middle of beat 7 of 16, then a fresh two-beat transfer.
    tput_mode = 0;
    start_xfer(16, 0);
    begin
      int n = 0;
      while (beat_k < 6 && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk("t6_reached_beat7", beat_k, 6);
    #1;
    active = 0;
    reset = 0;
    #1;
    check_reset_outputs("t6_async");
    beat_k = 0;
    reads_k = 0;
    cur_len = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_idle_busy", busy, 0);
    tput_mode = 1;
    start_xfer(2, 0);
    wait_done(50);
    chk("t6_d0", got[0], 64'd1);
    chk("t6_d1", got[1], 64'd2);
    chk("t6_tlast_count", tlast_count, 1);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmap_tx_logic.md
MMAP_TX_LOGIC -- requirements
Module: mmap_tx_logic

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, is the byte address of buffer word 0 on BRAM port B.
REQ-002 Parameter FIFO_DEPTH, default 4, is the output buffer depth in 64-bit words (power of two, 2..16).
REQ-003 clk  input  1  single block clock; all logic is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 start  input  1  one-cycle pulse that launches one buffer transfer.
REQ-006 length  input  13  number of 64-bit words to send, 1..4096; sampled on start.
REQ-007 busy  output  1  1 from the accepted start until the transfer and interrupt complete.
REQ-008 tx_tvalid / tx_tdata / tx_tlast  output  1/64/1  transmit stream toward the link.
REQ-009 tx_tready  input  1  sink ready; a beat transfers when tx_tvalid and tx_tready are both 1.
REQ-010 usr_irq_req / usr_irq_ack  output/input  1/1  completion interrupt handshake.
REQ-011 msi_enable / msi_vector_width  input  1/3  interrupt enable and MSI width; width is ignored by this block.
REQ-012 clkb, enb, web, addrb, dinb  output  1, 1, 8, 32, 64  BRAM port B: clkb = clk, web = 0, dinb = 0.
REQ-013 doutb  input  64  BRAM read data, valid exactly 1 cycle after the enb cycle.

Function
REQ-014 The state machine SHALL have the states IDLE, RUN, DRAIN, IRQ.
REQ-015 IDLE: on start=1 with length!=0, the block SHALL latch length, clear the counters and enter RUN. When length=0, start SHALL be ignored.
REQ-016 start while not in IDLE SHALL be ignored. The latched length SHALL NOT change mid-transfer.
REQ-017 RUN: the block SHALL assert enb in a cycle if and only if all of these hold:
- issued < length
- fifo_count + inflight + (1 if a beat is not popped this cycle) <= FIFO_DEPTH
The net effect is that the FIFO never overflows.
REQ-018 The read address SHALL be addrb = BASE_ADDR + 8*issued, a 32-bit byte address. issued SHALL increment by 1 for each enb.
REQ-019 doutb SHALL be pushed into the FIFO in the cycle after each enb. The read-to-FIFO latency is exactly 1 cycle.
REQ-020 tx_tvalid SHALL equal (FIFO not empty). tx_tdata SHALL be the FIFO head. Both SHALL stay stable while tx_tvalid=1 and tx_tready=0.
REQ-021 tx_tlast SHALL be 1 only on beat number length-1, counted from 0.
REQ-022 Push and pop in the same cycle SHALL leave fifo_count unchanged. Push into an empty FIFO SHALL raise tx_tvalid on the next cycle.
REQ-023 Minimum first-beat latency: start to tx_tvalid=1 is 3 cycles (latch, enb, push).
REQ-024 Throughput: with tx_tready held at 1, the block SHALL deliver one beat per cycle after the first beat.
REQ-025 RUN -> DRAIN when issued == length.
REQ-026 DRAIN -> IRQ when the tlast beat is accepted and msi_enable=1. DRAIN -> IDLE when that beat is accepted and msi_enable=0.
REQ-027 IRQ: usr_irq_req SHALL be held at 1 until usr_irq_ack=1 is sampled. The block then drops usr_irq_req and busy in the following cycle and enters IDLE.
REQ-028 A usr_irq_ack seen outside the IRQ state SHALL be ignored.
REQ-029 tx_tready=0 for any duration SHALL:
- stop reads once the FIFO plus in-flight reads total FIFO_DEPTH;
- lose no data and duplicate no data.
REQ-030 The beat counter SHALL span 0..4096 without wrap. length=4096 SHALL read addresses BASE_ADDR through BASE_ADDR+0x7FF8.

Reset
REQ-031 reset=0 SHALL force the following immediately, regardless of clk:
- state = IDLE;
- FIFO and all counters cleared;
- busy=0, tx_tvalid=0, tx_tlast=0, tx_tdata=0;
- usr_irq_req=0, enb=0, addrb=BASE_ADDR.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no further beats. After release, the block SHALL accept a new start only.

Verification
REQ-033 start with length=4, tx_tready=1, BRAM word n = n+1 -> 4 beats with tx_tdata 1,2,3,4 on consecutive cycles. First beat is 3 cycles after start. tx_tlast is set on beat 4.
REQ-034 Same transfer with msi_enable=1 and usr_irq_ack pulsed 5 cycles after tlast -> usr_irq_req=1 for exactly 5 cycles. busy=0 one cycle after the ack.
REQ-035 length=16 with tx_tready toggling randomly -> exactly 16 ordered beats. At most FIFO_DEPTH reads are outstanding beyond accepted beats. enb stops while the sink stalls.
REQ-036 length=4096, tx_tready=1 -> last addrb = BASE_ADDR+0x7FF8. 4096 beats. tlast only on the final beat.
REQ-037 A second start 2 cycles into a transfer, and a start with length=0 -> both ignored and busy is unchanged.
REQ-038 reset=0 during beat 7 of 16 -> all outputs are at reset values with no clk edge needed. A new start with length=2 afterwards yields 2 correct beats from BASE_ADDR.
